// File: rtl/tlul_err_gate.sv
// TL-UL error gate: forwards legal host requests to one device, absorbs illegal ones
// and answers them locally once every outstanding device transaction has drained.
package tlul_pkg;
    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;
    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [7:0]  a_mask;
        logic [63:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic [0:0]  d_sink;
        logic [63:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;
endpackage

// state     | meaning
// StIdle    | forwarding legal requests and device responses
// StDrain   | illegal request pending, waiting for outstanding device transactions to finish
// StErrResp | presenting the locally generated error response to the host
module tlul_err_gate
    import tlul_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned ErrCntW        = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  tl_h2d_t            tl_h_i,
    output tl_d2h_t            tl_h_o,
    output tl_h2d_t            tl_d_o,
    input  tl_d2h_t            tl_d_i,
    input  logic               err_i,
    output logic               busy_o,
    output logic [ErrCntW-1:0] err_cnt_o
);

    localparam int unsigned OutW = $clog2(MaxOutstanding + 1);
    localparam logic [OutW-1:0] MaxOut = OutW'(MaxOutstanding);

    typedef enum logic [1:0] {StIdle, StDrain, StErrResp} state_e;

    state_e             state_q, state_d;
    logic [OutW-1:0]    out_q, out_d;
    logic [2:0]         op_q, op_d;
    logic [1:0]         size_q, size_d;
    logic [7:0]         source_q, source_d;
    logic [ErrCntW-1:0] err_cnt_q, err_cnt_d;
    logic               has_room;
    logic               accept_err;
    logic               a_hs, d_hs;

    assign has_room = (out_q < MaxOut);

    always_comb begin
        state_d    = state_q;
        accept_err = 1'b0;
        op_d       = op_q;
        size_d     = size_q;
        source_d   = source_q;
        err_cnt_d  = err_cnt_q;

        tl_d_o           = tl_h_i;
        tl_d_o.a_valid   = 1'b0;
        tl_d_o.d_ready   = 1'b0;
        tl_h_o           = tl_d_i;
        tl_h_o.d_valid   = 1'b0;
        tl_h_o.a_ready   = 1'b0;

        unique case (state_q)
            StIdle: begin
                tl_h_o.d_valid = tl_d_i.d_valid;
                tl_d_o.d_ready = tl_h_i.d_ready;
                if (tl_h_i.a_valid) begin
                    if (!err_i) begin
                        tl_d_o.a_valid = has_room;
                        tl_h_o.a_ready = has_room & tl_d_i.a_ready;
                    end else if (out_q == '0) begin
                        accept_err = 1'b1;
                    end else begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                tl_h_o.d_valid = tl_d_i.d_valid;
                tl_d_o.d_ready = tl_h_i.d_ready;
                // A request that vanished or turned legal is not ours to absorb.
                if (!tl_h_i.a_valid || !err_i) begin
                    state_d = StIdle;
                end else if (out_q == '0) begin
                    accept_err = 1'b1;
                end
            end
            StErrResp: begin
                tl_h_o.d_valid  = 1'b1;
                tl_h_o.d_opcode = (op_q == Get) ? AccessAckData : AccessAck;
                tl_h_o.d_param  = '0;
                tl_h_o.d_size   = size_q;
                tl_h_o.d_source = source_q;
                tl_h_o.d_sink   = '0;
                tl_h_o.d_data   = '0;
                tl_h_o.d_error  = 1'b1;
                if (tl_h_i.d_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (accept_err) begin
            tl_h_o.a_ready = 1'b1;
            op_d           = tl_h_i.a_opcode;
            size_d         = tl_h_i.a_size;
            source_d       = tl_h_i.a_source;
            state_d        = StErrResp;
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + ErrCntW'(1);
            end
        end

        if (!rst_ni) begin
            tl_h_o.a_ready = 1'b0;
            tl_h_o.d_valid = 1'b0;
            tl_d_o.a_valid = 1'b0;
            tl_d_o.d_ready = 1'b0;
        end
    end

    // A stray response with nothing outstanding is forwarded but never counted.
    assign a_hs = tl_d_o.a_valid & tl_d_i.a_ready;
    assign d_hs = tl_d_i.d_valid & tl_d_o.d_ready & (out_q != '0);

    always_comb begin
        out_d = out_q;
        if (a_hs && !d_hs) begin
            out_d = out_q + OutW'(1);
        end else if (!a_hs && d_hs) begin
            out_d = out_q - OutW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            out_q     <= '0;
            op_q      <= '0;
            size_q    <= '0;
            source_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            op_q      <= op_d;
            size_q    <= size_d;
            source_q  <= source_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign busy_o    = rst_ni & ((out_q != '0) || (state_q != StIdle));
    assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_tlul_err_gate.sv
// Directed bench for tlul_err_gate; a second instance with a 3-bit counter covers saturation.
module tb_tlul_err_gate;
    import tlul_pkg::*;

    logic        clk;
    logic        rst_n;
    tl_h2d_t     h_i;
    tl_d2h_t     d_i;
    logic        err;
    tl_d2h_t     h_o, h_o_s;
    tl_h2d_t     d_o, d_o_s;
    logic        busy, busy_s;
    logic [15:0] cnt;
    logic [2:0]  cnt_s;

    int n_assert = 0;
    int n_fail   = 0;

    tlul_err_gate #(.MaxOutstanding(4), .ErrCntW(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .tl_h_i(h_i), .tl_h_o(h_o),
        .tl_d_o(d_o), .tl_d_i(d_i), .err_i(err), .busy_o(busy), .err_cnt_o(cnt)
    );

    tlul_err_gate #(.MaxOutstanding(4), .ErrCntW(3)) dut_sat (
        .clk_i(clk), .rst_ni(rst_n), .tl_h_i(h_i), .tl_h_o(h_o_s),
        .tl_d_o(d_o_s), .tl_d_i(d_i), .err_i(err), .busy_o(busy_s), .err_cnt_o(cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic host_a(input logic v, input logic [2:0] op, input logic [1:0] sz,
                          input logic [7:0] src, input logic [31:0] addr, input logic e);
        h_i.a_valid   = v;
        h_i.a_opcode  = op;
        h_i.a_param   = 3'h0;
        h_i.a_size    = sz;
        h_i.a_source  = src;
        h_i.a_address = addr;
        h_i.a_mask    = 8'hFF;
        h_i.a_data    = 64'h0123_4567_89AB_CDEF;
        err           = e;
    endtask

    task automatic dev_d(input logic v, input logic [2:0] op, input logic [1:0] sz,
                         input logic [7:0] src, input logic [63:0] data);
        d_i.d_valid  = v;
        d_i.d_opcode = op;
        d_i.d_param  = 3'h0;
        d_i.d_size   = sz;
        d_i.d_source = src;
        d_i.d_sink   = 1'b0;
        d_i.d_data   = data;
        d_i.d_error  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        h_i = '0;
        d_i = '0;
        d_i.a_ready = 1'b1;
        h_i.d_ready = 1'b1;
        host_a(1'b1, Get, 2'd3, 8'd5, 32'h8, 1'b0);
        dev_d(1'b0, AccessAck, 2'd0, 8'd0, 64'h0);

        // reset held with a valid request on the host port
        cyc(); cyc();
        #3;
        chk("rst_a_ready", 64'(h_o.a_ready), 64'h0);
        chk("rst_d_valid", 64'(h_o.d_valid), 64'h0);
        chk("rst_dev_a_valid", 64'(d_o.a_valid), 64'h0);
        chk("rst_err_cnt", 64'(cnt), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);

        // legal Get forwarded combinationally
        cyc();
        rst_n = 1'b1;
        #3;
        chk("get_dev_a_valid", 64'(d_o.a_valid), 64'h1);
        chk("get_dev_addr", 64'(d_o.a_address), 64'h8);
        chk("get_dev_source", 64'(d_o.a_source), 64'h5);
        chk("get_dev_size", 64'(d_o.a_size), 64'h3);
        chk("get_host_a_ready", 64'(h_o.a_ready), 64'h1);
        cyc();
        host_a(1'b0, Get, 2'd3, 8'd5, 32'h8, 1'b0);
        #3;
        chk("get_busy", 64'(busy), 64'h1);
        cyc();
        dev_d(1'b1, AccessAckData, 2'd3, 8'd5, 64'hDEAD_BEEF_CAFE_F00D);
        #3;
        chk("get_resp_valid", 64'(h_o.d_valid), 64'h1);
        chk("get_resp_data", h_o.d_data, 64'hDEAD_BEEF_CAFE_F00D);
        chk("get_resp_opcode", 64'(h_o.d_opcode), 64'(AccessAckData));
        chk("get_resp_source", 64'(h_o.d_source), 64'h5);
        chk("get_dev_d_ready", 64'(d_o.d_ready), 64'h1);
        cyc();
        dev_d(1'b0, AccessAck, 2'd0, 8'd0, 64'h0);
        #3;
        chk("get_idle_busy", 64'(busy), 64'h0);

        // four Puts fill the device, the fifth stalls
        for (int i = 0; i < 4; i++) begin
            cyc();
            host_a(1'b1, PutFullData, 2'd2, 8'(i), 32'h100 + 32'(i * 4), 1'b0);
            #3;
            chk("put_accept", 64'(h_o.a_ready), 64'h1);
        end
        cyc();
        host_a(1'b1, PutFullData, 2'd2, 8'd4, 32'h110, 1'b0);
        #3;
        chk("stall_dev_a_valid", 64'(d_o.a_valid), 64'h0);
        chk("stall_host_a_ready", 64'(h_o.a_ready), 64'h0);
        cyc();
        dev_d(1'b1, AccessAck, 2'd2, 8'd0, 64'h0);
        #3;
        chk("stall_during_dhs", 64'(d_o.a_valid), 64'h0);
        cyc();
        dev_d(1'b0, AccessAck, 2'd0, 8'd0, 64'h0);
        #3;
        chk("fifth_dev_a_valid", 64'(d_o.a_valid), 64'h1);
        chk("fifth_host_a_ready", 64'(h_o.a_ready), 64'h1);
        cyc();
        host_a(1'b0, Get, 2'd0, 8'd0, 32'h0, 1'b0);
        dev_d(1'b1, AccessAck, 2'd2, 8'd1, 64'h0);
        cyc();
        cyc();
        dev_d(1'b0, AccessAck, 2'd0, 8'd0, 64'h0);

        // illegal Put with two outstanding: drain first
        host_a(1'b1, PutFullData, 2'd2, 8'd9, 32'h200, 1'b1);
        #3;
        chk("ill_idle_a_ready", 64'(h_o.a_ready), 64'h0);
        cyc();
        #3;
        chk("drain_a_ready", 64'(h_o.a_ready), 64'h0);
        chk("drain_dev_a_valid", 64'(d_o.a_valid), 64'h0);
        cyc();
        dev_d(1'b1, AccessAck, 2'd2, 8'd2, 64'h0);
        #3;
        chk("drain_pass_d_valid", 64'(h_o.d_valid), 64'h1);
        chk("drain_a_ready_2", 64'(h_o.a_ready), 64'h0);
        cyc();
        dev_d(1'b1, AccessAck, 2'd2, 8'd3, 64'h0);
        #3;
        chk("drain_a_ready_1", 64'(h_o.a_ready), 64'h0);
        cyc();
        dev_d(1'b0, AccessAck, 2'd0, 8'd0, 64'h0);
        #3;
        chk("drain_accept", 64'(h_o.a_ready), 64'h1);
        cyc();
        host_a(1'b0, Get, 2'd0, 8'd0, 32'h0, 1'b0);
        #3;
        chk("err_put_d_valid", 64'(h_o.d_valid), 64'h1);
        chk("err_put_opcode", 64'(h_o.d_opcode), 64'(AccessAck));
        chk("err_put_error", 64'(h_o.d_error), 64'h1);
        chk("err_put_source", 64'(h_o.d_source), 64'h9);
        chk("err_put_size", 64'(h_o.d_size), 64'h2);
        chk("err_put_cnt", 64'(cnt), 64'h1);
        cyc();
        #3;
        chk("err_put_done", 64'(h_o.d_valid), 64'h0);

        // illegal Get while idle, host stalls the response
        cyc();
        h_i.d_ready = 1'b0;
        host_a(1'b1, Get, 2'd1, 8'd3, 32'h40, 1'b1);
        #3;
        chk("ill_get_accept", 64'(h_o.a_ready), 64'h1);
        cyc();
        host_a(1'b0, Get, 2'd0, 8'd0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("hold_d_valid", 64'(h_o.d_valid), 64'h1);
            chk("hold_opcode", 64'(h_o.d_opcode), 64'(AccessAckData));
            chk("hold_data", h_o.d_data, 64'h0);
            chk("hold_source", 64'(h_o.d_source), 64'h3);
            chk("hold_size", 64'(h_o.d_size), 64'h1);
            chk("hold_error", 64'(h_o.d_error), 64'h1);
            cyc();
        end
        h_i.d_ready = 1'b1;
        host_a(1'b1, Get, 2'd0, 8'd7, 32'h0, 1'b1);
        #3;
        chk("hs_d_valid", 64'(h_o.d_valid), 64'h1);
        chk("hs_no_accept", 64'(h_o.a_ready), 64'h0);
        cyc();
        #3;
        chk("post_hs_d_valid", 64'(h_o.d_valid), 64'h0);
        chk("post_hs_accept", 64'(h_o.a_ready), 64'h1);
        chk("post_hs_cnt", 64'(cnt), 64'h2);

        // reset during an error response
        cyc();
        host_a(1'b0, Get, 2'd0, 8'd0, 32'h0, 1'b0);
        h_i.d_ready = 1'b0;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        #3;
        chk("rst_mid_d_valid", 64'(h_o.d_valid), 64'h0);
        chk("rst_mid_busy", 64'(busy), 64'h0);
        chk("rst_mid_cnt", 64'(cnt), 64'h0);

        // stray device response with nothing outstanding
        cyc();
        h_i.d_ready = 1'b1;
        dev_d(1'b1, AccessAck, 2'd0, 8'd1, 64'h0);
        #3;
        chk("stray_pass", 64'(h_o.d_valid), 64'h1);
        cyc();
        dev_d(1'b0, AccessAck, 2'd0, 8'd0, 64'h0);
        #3;
        chk("stray_busy", 64'(busy), 64'h0);

        // ten back-to-back illegal requests: narrow counter saturates at 7
        for (int i = 0; i < 10; i++) begin
            cyc();
            host_a(1'b1, PutPartialData, 2'd0, 8'(i), 32'h0, 1'b1);
            cyc();
            host_a(1'b0, Get, 2'd0, 8'd0, 32'h0, 1'b0);
        end
        cyc();
        #3;
        chk("cnt_ten", 64'(cnt), 64'd10);
        chk("cnt_sat", 64'(cnt_s), 64'd7);
        chk("sat_idle_busy", 64'(busy_s), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
